fft_frame_scheduler: RTL

- Sequences the FFT pitch-detection datapath. Packs the incoming audio sample stream into a two-bank (ping-pong) frame buffer.
- Launches the FFT core on each full frame and scans the returned magnitude stream for the peak bin.
- Emits the peak bin index as the pitch result on a valid/ready stream.
- Sits between the audio input stream and the FFT core, in the system clock domain. Samples arrive already synchronised to clk.

---
 rtl/fft_frame_scheduler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fft_frame_scheduler.sv
// ============================================================================
//  Module   : fft_frame_scheduler
//  Purpose  : Packs audio samples into a ping-pong frame buffer, launches the
//             FFT on each full frame, tracks the peak magnitude bin and
//             emits it as the pitch result on a valid/ready stream.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_frame_scheduler #(
    parameter int NSAMPLES = 1024,
    parameter int W        = 16,
    parameter int MW       = 33,
    parameter int MIN_BIN  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [W-1:0]                in_data,
    output logic                        buf_we,
    output logic                        buf_bank,
    output logic [$clog2(NSAMPLES)-1:0] buf_waddr,
    output logic [W-1:0]                buf_wdata,
    output logic                        fft_start,
    output logic                        fft_bank,
    input  logic                        mag_valid,
    input  logic [MW-1:0]               mag_data,
    output logic                        pitch_valid,
    input  logic                        pitch_ready,
    output logic [$clog2(NSAMPLES)-1:0] pitch_data,
    output logic                        protocol_err
);

    localparam int              c_aw      = $clog2(NSAMPLES);
    localparam logic [c_aw-1:0] c_last    = c_aw'(NSAMPLES - 1);
    localparam logic [c_aw-1:0] c_min_bin = c_aw'(MIN_BIN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_aw-1:0] r_waddr;
    logic            r_wbank;
    logic [1:0]      r_full;
    logic            r_next_fft_bank;
    logic [c_aw-1:0] r_bin;
    logic [MW-1:0]   r_max;
    logic [c_aw-1:0] r_maxbin;
    logic [c_aw-1:0] r_pitch_data;
    logic            r_err;

    logic            w_accept;
    logic            w_frame_done;
    logic            w_launch;
    logic            w_beat_run;
    logic            w_release;
    logic            w_in_search;
    logic            w_better;
    logic [1:0]      w_set;
    logic [1:0]      w_clr;

    // Writer may only fill the bank it points at once that bank is drained.
    assign in_ready     = ~r_full[r_wbank];
    assign w_accept     = in_valid & in_ready;
    assign w_frame_done = w_accept && (r_waddr == c_last);

    // Accepted samples pass straight through to the buffer write port.
    assign buf_we    = w_accept;
    assign buf_bank  = w_accept ? r_wbank : 1'b0;
    assign buf_waddr = w_accept ? r_waddr : '0;
    assign buf_wdata = w_accept ? in_data : '0;

    // Upper half of the spectrum mirrors the lower half, so it is skipped.
    assign w_launch    = (r_state == S_IDLE) && r_full[r_next_fft_bank];
    assign w_beat_run  = (r_state == S_RUN) && mag_valid;
    assign w_release   = w_beat_run && (r_bin == c_last);
    assign w_in_search = (r_bin >= c_min_bin) && !r_bin[c_aw-1];
    assign w_better    = w_beat_run && w_in_search && (mag_data > r_max);

    // Frame completion and release always hit different banks.
    assign w_set = {w_frame_done &  r_wbank,         w_frame_done & ~r_wbank};
    assign w_clr = {w_release    &  r_next_fft_bank, w_release    & ~r_next_fft_bank};

    // The FFT reads the oldest unreleased bank; it only moves on release.
    assign fft_bank     = r_next_fft_bank;
    assign pitch_data   = r_pitch_data;
    assign protocol_err = r_err;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and control outputs.
    always_comb begin
        w_state_nxt = r_state;
        fft_start   = 1'b0;
        pitch_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_full[r_next_fft_bank]) begin
                    fft_start   = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (mag_valid && (r_bin == c_last)) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                pitch_valid = 1'b1;
                if (pitch_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Write-side address, bank and occupancy tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_waddr <= '0;
            r_wbank <= 1'b0;
            r_full  <= 2'b00;
        end else begin
            if (w_accept) begin
                r_waddr <= r_waddr + 1'b1;
            end
            if (w_frame_done) begin
                r_wbank <= ~r_wbank;
            end
            r_full <= (r_full | w_set) & ~w_clr;
        end
    end

    // Peak search over the magnitude stream and pitch result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin           <= '0;
            r_max           <= '0;
            r_maxbin        <= '0;
            r_pitch_data    <= '0;
            r_next_fft_bank <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            if (w_launch) begin
                r_bin    <= '0;
                r_max    <= '0;
                r_maxbin <= '0;
            end else if (w_beat_run) begin
                r_bin <= r_bin + 1'b1;
                if (w_better) begin
                    r_max    <= mag_data;
                    r_maxbin <= r_bin;
                end
            end
            if (w_release) begin
                r_next_fft_bank <= ~r_next_fft_bank;
                r_pitch_data    <= r_maxbin;
            end
            if (mag_valid && (r_state != S_RUN)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
